muldiv_unit: RTL and testbench



---
 rtl/arki_pkg.sv | 31 +++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/arki_pkg.sv
// Shared types and constants for the Arki multiply/divide datapath.
package arki_pkg;

  localparam int unsigned XLEN = 64;

  // Register index that reads as zero and discards writes.
  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    OpMul  = 2'b00,
    OpUdiv = 2'b01,
    OpSdiv = 2'b10
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } muldiv_state_t;

  // The reserved encoding 2'b11 executes as a multiply.
  function automatic muldiv_op_t decode_op(input logic [1:0] raw);
    case (raw)
      2'b01:   return OpUdiv;
      2'b10:   return OpSdiv;
      default: return OpMul;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, trial-subtract for restoring divide.
module muldiv_step #(
  parameter int unsigned XLEN = 64
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  input  logic              i_div,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rem;
  logic [XLEN:0] w_diff;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  // Divide:   acc = {remainder, dividend bits / quotient bits}, shifted left each step.
  always_comb begin
    w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    w_rem  = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
    w_diff = w_rem - {1'b0, i_opnd};
    if (!i_div) begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end else if (!w_diff[XLEN]) begin
      // No borrow: keep the difference and shift in a quotient 1.
      o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
    end else begin
      // Borrow: restore the shifted remainder and shift in a quotient 0.
      o_acc = {w_rem[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: fixed 66-cycle start-to-done latency for every op.
module muldiv_unit #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned ITERS = 64  // must equal XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wa,
  output logic            we
);

  import arki_pkg::*;

  localparam int unsigned   CW      = $clog2(ITERS);
  localparam logic [CW-1:0] LastCnt = CW'(ITERS - 1);

  muldiv_state_t     r_state;
  muldiv_state_t     w_state_nxt;
  muldiv_op_t        r_op;
  muldiv_op_t        w_op_in;
  logic [CW-1:0]     r_count;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] w_acc_step;
  logic [XLEN-1:0]   r_opnd;
  logic [4:0]        r_rd;
  logic              r_neg;
  logic              w_load;
  logic              w_iter;
  logic              w_fix;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_fix_res;

  // Next-state logic; kill wins over start and over iteration.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_iter      = 1'b0;
    w_fix       = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (start && !kill) begin
          w_state_nxt = StRun;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      StRun: begin
        if (kill) begin
          w_state_nxt = StIdle;
        end else begin
          w_iter = 1'b1;
          if (r_count == '0) begin
            w_state_nxt = StFix;
          end
        end
      end
      StFix: begin
        if (kill) begin
          w_state_nxt = StIdle;
        end else begin
          w_fix       = 1'b1;
          w_state_nxt = StDone;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Operand conditioning: signed divide works on magnitudes and fixes the sign at the end.
  always_comb begin
    w_op_in = decode_op(op);
    w_a_neg = (w_op_in == OpSdiv) && a[XLEN-1];
    w_b_neg = (w_op_in == OpSdiv) && b[XLEN-1];
    w_a_mag = w_a_neg ? -a : a;
    w_b_mag = w_b_neg ? -b : b;
  end

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .i_div  (r_op != OpMul),
    .o_acc  (w_acc_step)
  );

  // Final result: sign correction and divide-by-zero. The most-negative / -1 case needs no
  // special handling: both signs are negative, so the 2^(XLEN-1) magnitude wraps as required.
  always_comb begin
    w_quot = r_acc[XLEN-1:0];
    if (r_op == OpMul) begin
      w_fix_res = w_quot;
    end else if (r_opnd == '0) begin
      w_fix_res = '0;
    end else if ((r_op == OpSdiv) && r_neg) begin
      w_fix_res = -w_quot;
    end else begin
      w_fix_res = w_quot;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operation context, accumulator and iteration counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= OpMul;
      r_rd    <= '0;
      r_neg   <= 1'b0;
      r_count <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
    end else if (w_load) begin
      r_op    <= w_op_in;
      r_rd    <= rd_in;
      r_neg   <= w_a_neg ^ w_b_neg;
      r_count <= LastCnt;
      if (w_op_in == OpMul) begin
        r_acc  <= {{XLEN{1'b0}}, b};
        r_opnd <= a;
      end else begin
        r_acc  <= {{XLEN{1'b0}}, w_a_mag};
        r_opnd <= w_b_mag;
      end
    end else if (w_iter) begin
      r_acc <= w_acc_step;
      if (r_count != '0) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Result and destination update only on the FIX -> DONE edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
      wa     <= '0;
    end else if (w_fix) begin
      result <= w_fix_res;
      wa     <= r_rd;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = (r_state == StRun) || (r_state == StFix);
    done = (r_state == StDone);
    we   = done && (wa != XZR);
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at start, checked at done.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 64;
  localparam logic [63:0] MinNeg = 64'h8000_0000_0000_0000;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic [4:0]      rd_in = '0;
  logic            kill = 1'b0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      wa;
  logic            we;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  wa;
    logic        we;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] last_exp = '0;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_done = 0;
  int          nd0;

  muldiv_unit #(
    .XLEN  (XLEN),
    .ITERS (XLEN)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .rd_in   (rd_in),
    .kill    (kill),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .wa      (wa),
    .we      (we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] x,
                                        input logic [63:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    sx = x;
    sy = y;
    case (o)
      2'b01: model = (y == 64'd0) ? 64'd0 : x / y;
      2'b10: begin
        if (y == 64'd0) model = 64'd0;
        else if (x == MinNeg && y == 64'hFFFF_FFFF_FFFF_FFFF) model = MinNeg;
        else model = sx / sy;
      end
      default: model = x * y;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                        input logic [4:0] rd, input bit push);
    exp_t ex;
    op    = o;
    a     = x;
    b     = y;
    rd_in = rd;
    start = 1'b1;
    if (push) begin
      ex.res = model(o, x, y);
      ex.wa  = rd;
      ex.we  = (rd != 5'd31);
      sb.push_back(ex);
      last_exp = ex.res;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  // Counts edges from the accepting edge until done is seen (bounded).
  task automatic wait_done();
    int lat;
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd66);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                       input logic [4:0] rd);
    launch(o, x, y, rd, 1'b1);
    wait_done();
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(posedge clk) begin
    #1;
    if (reset_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("wa", {59'd0, wa}, {59'd0, mon_e.wa});
        check("we", {63'd0, we}, {63'd0, mon_e.we});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #23;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_we", {63'd0, we}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_wa", {59'd0, wa}, 64'd0);
    #4 reset_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(2'b00, 64'd7, 64'd6, 5'd3);
    idle(1);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    idle(2);
    do_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4);
    idle(2);
    do_op(2'b10, -64'd7, 64'd2, 5'd5);
    idle(1);
    do_op(2'b01, 64'd100, 64'd7, 5'd6);
    idle(1);
    do_op(2'b01, 64'd5, 64'd0, 5'd7);
    idle(1);
    do_op(2'b10, MinNeg, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8);
    idle(1);
    do_op(2'b10, 64'd9, -64'd3, 5'd9);
    idle(1);
    do_op(2'b10, 64'd5, 64'd0, 5'd10);
    idle(1);
    do_op(2'b11, 64'd6, 64'd7, 5'd11);
    idle(1);
    do_op(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd12);
    idle(1);
    do_op(2'b00, 64'd3, 64'd3, 5'd31);
    idle(2);

    // A second start mid-operation must be ignored.
    nd0 = n_done;
    launch(2'b00, 64'd11, 64'd13, 5'd14, 1'b1);
    idle(9);
    op    = 2'b01;
    a     = 64'd1;
    b     = 64'd1;
    rd_in = 5'd15;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    idle(100);
    check("ignored_start_done_count", 64'(n_done - nd0), 64'd1);

    // Kill mid-divide: back to idle, no done, result retained.
    launch(2'b01, 64'd1000, 64'd3, 5'd16, 1'b0);
    idle(29);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_busy", {63'd0, busy}, 64'd0);
    check("kill_done", {63'd0, done}, 64'd0);
    nd0 = n_done;
    idle(80);
    check("kill_no_done", 64'(n_done - nd0), 64'd0);
    check("kill_result_kept", result, last_exp);

    // Back-to-back: second start issued in the DONE cycle.
    do_op(2'b00, 64'd3, 64'd5, 5'd2);
    do_op(2'b10, -64'd100, 64'd7, 5'd17);
    idle(2);

    // Asynchronous reset mid-multiply.
    launch(2'b00, 64'd123, 64'd456, 5'd18, 1'b0);
    idle(19);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_done", {63'd0, done}, 64'd0);
    check("async_rst_result", result, 64'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(2'b00, 64'd12, 64'd12, 5'd19);
    idle(2);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
